p_hit_dispatch: RTL and testbench
=================================

// Module: p_hit_dispatch
// PURPOSE
//  Write-side feeder for the p_hit intersection-point pipeline.
//  - Pops one ray/triangle job per transaction from an upstream show-ahead FIFO.
//  - Fans the job out to the four p_hit input FIFO lanes, each with its own wr_en/full pair:
//    lane0 = normal/v0/origin, lane1 = normal/dir, lane2 = dir_2, lane3 = origin_2.
//  - Tracks per-lane acceptance so that every lane receives exactly one write per job.
// PARAMETERS
//  NUM_LANES   4    downstream FIFO lanes; fixed by the p_hit input interface
//  CNT_BITS    16   width of the job_count counter
// PORTS
//  clock         in   1        single clock; all state on rising edge
//  reset         in   1        asynchronous, active-low reset
//  in_normal     in   32s[3]   triangle normal x,y,z (Q16.16)
//  in_v0         in   32s[3]   triangle vertex 0 (Q16.16)
//  in_origin     in   32s[3]   ray origin (Q16.16)
//  in_dir        in   32s[3]   ray direction (Q16.16)
//  in_empty      in   1        upstream FIFO empty; in_* valid when low (show-ahead)
//  in_rd_en      out  1        pop upstream; one-cycle pulse per accepted job
//  tri_normal_1  out  32s[3]   held job normal -> lane0
//  tri_normal_2  out  32s[3]   held job normal -> lane1
//  v0            out  32s[3]   held vertex 0 -> lane0
//  origin_1      out  32s[3]   held origin -> lane0
//  origin_2      out  32s[3]   held origin -> lane3
//  dir_1         out  32s[3]   held direction -> lane1
//  dir_2         out  32s[3]   held direction -> lane2
//  out_full      in   [NUM_LANES]  per-lane downstream FIFO full
//  out_wr_en     out  [NUM_LANES]  per-lane downstream write strobe
//  busy          out  1        job held with at least one lane pending
//  job_count     out  CNT_BITS number of jobs fully dispatched (all lanes written)
// BEHAVIOUR
//  - Reset (reset=0, async):
//    - state=IDLE, pending=0, all data registers 0.
//    - in_rd_en=0, out_wr_en=0, busy=0, job_count=0.
//  - States:
//    - IDLE: no job held.
//    - SEND: job held in registers, pending mask non-zero.
//  - Capture:
//    - Occurs when (state==IDLE || last pending lanes complete this cycle) && !in_empty.
//    - in_rd_en=1 that cycle; in_* latched into data registers.
//    - pending <= all ones; state <= SEND.
//  - Lane writes:
//    - out_wr_en[i] = (state==SEND) && pending[i] && !out_full[i]. This is combinational from out_full.
//    - pending[i] clears on the edge where out_wr_en[i]=1.
//  - Completion:
//    - Occurs when (pending & ~writes_this_cycle)==0 in SEND.
//    - job_count increments, wrapping at 2^CNT_BITS-1 -> 0.
//    - If !in_empty the same cycle, the next job is captured (back-to-back, 1 job/cycle when no lane is full).
//    - Otherwise state <= IDLE.
//  - Latency:
//    - Pop-to-first-write is 1 cycle.
//    - Data outputs change only on a capture edge and stay stable while any lane is pending.
//  - Full handling:
//    - A full lane stalls only itself; other lanes write and clear independently.
//    - No lane is ever written twice for one job.
//  - Empty handling: in IDLE with in_empty=1, in_rd_en=0 and outputs hold their last values.
//  - busy = (state==SEND).
//  - Reset mid-job: pending job is dropped, no further writes; upstream entry already popped is lost (accepted).
//  - No arithmetic is performed. Data passes bit-exact, sign preserved.
// STRUCTURE
//  - p_hit_pkg (shared):
//    - typedef logic signed [31:0] vec3_t [2:0];
//    - localparam NUM_LANES=4; lane index constants LANE_N0, LANE_N1, LANE_DIR2, LANE_ORG2;
//    - enum {IDLE, SEND} dispatch_state_t.
//  - Single module, no sub-module: job register bank, pending mask, 2-state FSM, counter.
// TESTING
//  - Single job, all lanes empty:
//    - Inputs: in_normal=(1,2,3), in_dir=(0x10000,0,0), in_empty low for 1 cycle.
//    - Required: in_rd_en one pulse; out_wr_en=4'b1111 next cycle only.
//    - Required: lane data matches bit-exact; job_count=1.
//  - Lane 2 full for 5 cycles:
//    - Required: lanes 0,1,3 write at cycle 1; lane2 writes in the cycle out_full[2] drops.
//    - Required: busy high throughout; no second pop until then.
//  - Stream of 8 jobs, no full:
//    - Required: in_rd_en high 8 consecutive cycles; out_wr_en=4'b1111 for 8 consecutive cycles.
//    - Required: job_count=8.
//  - Reset asserted while lanes 1,3 pending:
//    - Required: out_wr_en=0 immediately; busy=0; job_count=0.
//    - Required: after release, next job dispatches normally.
//  - Negative data: in_v0=(0xFFFF0000,-1,0x80000000) -> v0 outputs identical, sign intact.
//  - job_count wrap with CNT_BITS=2: 5 jobs -> job_count=1.

Source files
------------

// File: rtl/p_hit_pkg.sv
// Shared types and constants for the p_hit input-side logic.
package p_hit_pkg;

  typedef logic signed [31:0] vec3_t [2:0];

  localparam int NUM_LANES = 4;

  // Lane index constants for the p_hit input FIFOs
  localparam int LANE_N0   = 0;  // normal / v0 / origin
  localparam int LANE_N1   = 1;  // normal / dir
  localparam int LANE_DIR2 = 2;  // dir_2
  localparam int LANE_ORG2 = 3;  // origin_2

  typedef logic [NUM_LANES-1:0] lane_mask_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } dispatch_state_t;

endpackage

// File: rtl/p_hit_dispatch.sv
// Write-side feeder for the p_hit pipeline: pops one job from a show-ahead
// FIFO, holds it, and writes it exactly once into each of the four lanes.
//
//   state | meaning
//   IDLE  | no job held
//   SEND  | job held in registers, at least one lane still pending
module p_hit_dispatch
  import p_hit_pkg::*;
#(
  parameter int CNT_BITS = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  vec3_t                in_normal,
  input  vec3_t                in_v0,
  input  vec3_t                in_origin,
  input  vec3_t                in_dir,
  input  logic                 in_empty,
  output logic                 in_rd_en,
  output vec3_t                tri_normal_1,
  output vec3_t                tri_normal_2,
  output vec3_t                v0,
  output vec3_t                origin_1,
  output vec3_t                origin_2,
  output vec3_t                dir_1,
  output vec3_t                dir_2,
  input  logic [NUM_LANES-1:0] out_full,
  output logic [NUM_LANES-1:0] out_wr_en,
  output logic                 busy,
  output logic [CNT_BITS-1:0]  job_count
);

  dispatch_state_t     state_q, state_d;
  lane_mask_t          pending_q, pending_d;
  logic [CNT_BITS-1:0] job_cnt_q, job_cnt_d;

  vec3_t normal_q, v0_q, origin_q, dir_q;

  lane_mask_t lane_wr;
  lane_mask_t remaining;
  logic       done;
  logic       capture;

  // A lane writes when the job is held, the lane is still owed data and it has room
  assign lane_wr   = (state_q == SEND) ? (pending_q & ~out_full) : '0;
  assign remaining = pending_q & ~lane_wr;

  // State register: FSM state, pending mask and dispatched-job counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      job_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      job_cnt_q <= job_cnt_d;
    end
  end

  // Next state: completion frees the registers so a waiting job can be taken the same cycle
  always_comb begin
    done      = (state_q == SEND) && (remaining == '0);
    capture   = ((state_q == IDLE) || done) && !in_empty;
    state_d   = state_q;
    pending_d = (state_q == SEND) ? remaining : '0;
    job_cnt_d = job_cnt_q;

    if (done) begin
      job_cnt_d = job_cnt_q + CNT_BITS'(1);
      state_d   = IDLE;
    end
    if (capture) begin
      state_d   = SEND;
      pending_d = '1;
    end
  end

  // Outputs: pop strobe, lane strobes and busy flag
  always_comb begin
    in_rd_en  = capture;
    out_wr_en = lane_wr;
    busy      = (state_q == SEND);
  end

  // Job register bank; only a capture edge changes the held data
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      normal_q <= '{default: '0};
      v0_q     <= '{default: '0};
      origin_q <= '{default: '0};
      dir_q    <= '{default: '0};
    end else if (capture) begin
      normal_q <= in_normal;
      v0_q     <= in_v0;
      origin_q <= in_origin;
      dir_q    <= in_dir;
    end
  end

  assign tri_normal_1 = normal_q;
  assign tri_normal_2 = normal_q;
  assign v0           = v0_q;
  assign origin_1     = origin_q;
  assign origin_2     = origin_q;
  assign dir_1        = dir_q;
  assign dir_2        = dir_q;
  assign job_count    = job_cnt_q;

endmodule

// File: tb/tb_p_hit_dispatch.sv
// Bench for p_hit_dispatch: directed jobs with a per-lane scoreboard.
module tb_p_hit_dispatch;
  import p_hit_pkg::*;

  logic       clock;
  logic       reset;
  vec3_t      in_normal, in_v0, in_origin, in_dir;
  logic       in_empty;
  logic       in_rd_en;
  vec3_t      tri_normal_1, tri_normal_2, v0, origin_1, origin_2, dir_1, dir_2;
  logic [3:0] out_full;
  logic [3:0] out_wr_en;
  logic       busy;
  logic [15:0] job_count;

  logic       w_rd_en;
  vec3_t      w_n1, w_n2, w_v0, w_o1, w_o2, w_d1, w_d2;
  logic [3:0] w_wr_en;
  logic       w_busy;
  logic [1:0] w_job_count;

  typedef struct packed {
    logic [95:0] n;
    logic [95:0] v;
    logic [95:0] o;
    logic [95:0] d;
  } job_t;

  job_t q0[$], q1[$], q2[$], q3[$];
  int n_checks = 0;
  int n_err    = 0;

  p_hit_dispatch #(.CNT_BITS(16)) u_dut (
    .clock(clock), .reset(reset),
    .in_normal(in_normal), .in_v0(in_v0), .in_origin(in_origin), .in_dir(in_dir),
    .in_empty(in_empty), .in_rd_en(in_rd_en),
    .tri_normal_1(tri_normal_1), .tri_normal_2(tri_normal_2), .v0(v0),
    .origin_1(origin_1), .origin_2(origin_2), .dir_1(dir_1), .dir_2(dir_2),
    .out_full(out_full), .out_wr_en(out_wr_en), .busy(busy), .job_count(job_count)
  );

  p_hit_dispatch #(.CNT_BITS(2)) u_dut_wrap (
    .clock(clock), .reset(reset),
    .in_normal(in_normal), .in_v0(in_v0), .in_origin(in_origin), .in_dir(in_dir),
    .in_empty(in_empty), .in_rd_en(w_rd_en),
    .tri_normal_1(w_n1), .tri_normal_2(w_n2), .v0(w_v0),
    .origin_1(w_o1), .origin_2(w_o2), .dir_1(w_d1), .dir_2(w_d2),
    .out_full(out_full), .out_wr_en(w_wr_en), .busy(w_busy), .job_count(w_job_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [95:0] p3(input vec3_t a);
    return {a[2], a[1], a[0]};
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_job(input logic [95:0] n, input logic [95:0] v,
                           input logic [95:0] o, input logic [95:0] d);
    job_t j;
    for (int k = 0; k < 3; k++) begin
      in_normal[k] = n[32*k +: 32];
      in_v0[k]     = v[32*k +: 32];
      in_origin[k] = o[32*k +: 32];
      in_dir[k]    = d[32*k +: 32];
    end
    in_empty = 1'b0;
    j = '{n: n, v: v, o: o, d: d};
    q0.push_back(j);
    q1.push_back(j);
    q2.push_back(j);
    q3.push_back(j);
  endtask

  function automatic logic [95:0] pat(input int s);
    return {32'(s * 3 + 2), 32'(s * 3 + 1), 32'(s * 3)};
  endfunction

  // Monitor: every lane write must match the oldest job still owed to that lane
  always @(negedge clock) begin
    job_t e;
    #2;
    if (out_wr_en[0]) begin
      if (q0.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL lane0_extra_write: actual=write required=none");
      end else begin
        e = q0.pop_front();
        chk("lane0_normal", p3(tri_normal_1), e.n);
        chk("lane0_v0",     p3(v0),           e.v);
        chk("lane0_origin", p3(origin_1),     e.o);
      end
    end
    if (out_wr_en[1]) begin
      if (q1.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL lane1_extra_write: actual=write required=none");
      end else begin
        e = q1.pop_front();
        chk("lane1_normal", p3(tri_normal_2), e.n);
        chk("lane1_dir",    p3(dir_1),        e.d);
      end
    end
    if (out_wr_en[2]) begin
      if (q2.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL lane2_extra_write: actual=write required=none");
      end else begin
        e = q2.pop_front();
        chk("lane2_dir", p3(dir_2), e.d);
      end
    end
    if (out_wr_en[3]) begin
      if (q3.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL lane3_extra_write: actual=write required=none");
      end else begin
        e = q3.pop_front();
        chk("lane3_origin", p3(origin_2), e.o);
      end
    end
  end

  initial begin
    reset    = 1'b0;
    in_empty = 1'b1;
    out_full = 4'b0000;
    in_normal = '{default: '0};
    in_v0     = '{default: '0};
    in_origin = '{default: '0};
    in_dir    = '{default: '0};

    #1;
    chk("rst_rd_en", 96'(in_rd_en), 96'(0));
    chk("rst_wr_en", 96'(out_wr_en), 96'(0));
    chk("rst_busy",  96'(busy), 96'(0));
    chk("rst_count", 96'(job_count), 96'(0));
    chk("rst_v0",    p3(v0), 96'(0));

    @(negedge clock);
    reset = 1'b1;

    // Single job, all lanes free
    @(negedge clock);
    drive_job({32'd3, 32'd2, 32'd1}, {32'h7, 32'h6, 32'h5},
              {32'hC, 32'hB, 32'hA}, {32'd0, 32'd0, 32'h10000});
    #1;
    chk("t1_rd_pulse", 96'(in_rd_en), 96'(1));
    chk("t1_wr_before", 96'(out_wr_en), 96'(0));
    @(negedge clock);
    in_empty = 1'b1;
    #1;
    chk("t1_rd_after", 96'(in_rd_en), 96'(0));
    chk("t1_wr_all", 96'(out_wr_en), 96'hF);
    chk("t1_busy", 96'(busy), 96'(1));
    @(negedge clock);
    #1;
    chk("t1_wr_once", 96'(out_wr_en), 96'(0));
    chk("t1_idle", 96'(busy), 96'(0));
    chk("t1_count", 96'(job_count), 96'(1));

    // Lane 2 held full for five cycles while a second job waits upstream
    @(negedge clock);
    out_full = 4'b0100;
    drive_job(pat(10), pat(11), pat(12), pat(13));
    #1;
    chk("t2_rd_a", 96'(in_rd_en), 96'(1));
    @(negedge clock);
    drive_job(pat(20), pat(21), pat(22), pat(23));
    #1;
    chk("t2_wr_partial", 96'(out_wr_en), 96'b1011);
    chk("t2_no_pop", 96'(in_rd_en), 96'(0));
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      #1;
      chk("t2_stall_wr", 96'(out_wr_en), 96'(0));
      chk("t2_stall_rd", 96'(in_rd_en), 96'(0));
      chk("t2_stall_busy", 96'(busy), 96'(1));
    end
    @(negedge clock);
    out_full = 4'b0000;
    #1;
    chk("t2_lane2_wr", 96'(out_wr_en), 96'b0100);
    chk("t2_rd_b", 96'(in_rd_en), 96'(1));
    @(negedge clock);
    in_empty = 1'b1;
    #1;
    chk("t2_b_wr_all", 96'(out_wr_en), 96'hF);
    chk("t2_b_rd", 96'(in_rd_en), 96'(0));
    @(negedge clock);
    #1;
    chk("t2_idle", 96'(busy), 96'(0));
    chk("t2_count", 96'(job_count), 96'(3));

    // Back-to-back stream of eight jobs
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      drive_job(pat(100 + 4*i), pat(101 + 4*i), pat(102 + 4*i), pat(103 + 4*i));
      #1;
      chk("t3_rd_stream", 96'(in_rd_en), 96'(1));
      if (i > 0) chk("t3_wr_stream", 96'(out_wr_en), 96'hF);
    end
    @(negedge clock);
    in_empty = 1'b1;
    #1;
    chk("t3_wr_last", 96'(out_wr_en), 96'hF);
    chk("t3_rd_stop", 96'(in_rd_en), 96'(0));
    @(negedge clock);
    #1;
    chk("t3_wr_done", 96'(out_wr_en), 96'(0));
    chk("t3_count", 96'(job_count), 96'(11));
    chk("t3_count_wrap", 96'(w_job_count), 96'(3));

    // Reset while lanes 1 and 3 are pending
    @(negedge clock);
    out_full = 4'b1010;
    drive_job(pat(300), pat(301), pat(302), pat(303));
    #1;
    chk("t4_rd", 96'(in_rd_en), 96'(1));
    @(negedge clock);
    in_empty = 1'b1;
    #1;
    chk("t4_wr_partial", 96'(out_wr_en), 96'b0101);
    @(negedge clock);
    #1;
    chk("t4_pending", 96'(busy), 96'(1));
    #2;
    reset = 1'b0;
    #1;
    chk("t4_rst_wr", 96'(out_wr_en), 96'(0));
    chk("t4_rst_busy", 96'(busy), 96'(0));
    chk("t4_rst_count", 96'(job_count), 96'(0));
    chk("t4_rst_count_w", 96'(w_job_count), 96'(0));
    chk("t4_dropped_l1", 96'(q1.size()), 96'(1));
    chk("t4_dropped_l3", 96'(q3.size()), 96'(1));
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    out_full = 4'b0000;
    @(negedge clock);
    reset = 1'b1;

    // Five jobs after reset: sign-extreme data first, and counter wrap on the 2-bit copy
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (i == 0)
        drive_job(pat(500), {32'h80000000, 32'hFFFFFFFF, 32'hFFFF0000}, pat(502), pat(503));
      else
        drive_job(pat(500 + 4*i), pat(501 + 4*i), pat(502 + 4*i), pat(503 + 4*i));
      #1;
      chk("t5_rd", 96'(in_rd_en), 96'(1));
      if (i == 1) begin
        chk("t5_first_wr", 96'(out_wr_en), 96'hF);
        n_checks++;
        if (v0[1] !== -32'sd1 || v0[2] >= 0 || v0[0] >= 0) begin
          n_err++;
          $display("FAIL t5_v0_sign: actual=%0h required=80000000ffffffffffff0000", p3(v0));
        end
      end
    end
    @(negedge clock);
    in_empty = 1'b1;
    @(negedge clock);
    #1;
    chk("t5_count", 96'(job_count), 96'(5));
    chk("t5_count_wrap", 96'(w_job_count), 96'(1));

    #3;
    chk("end_q0_drained", 96'(q0.size()), 96'(0));
    chk("end_q1_drained", 96'(q1.size()), 96'(0));
    chk("end_q2_drained", 96'(q2.size()), 96'(0));
    chk("end_q3_drained", 96'(q3.size()), 96'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
